row_clear_ctrl: RTL and testbench
=================================

ROW_CLEAR_CTRL -- requirements
Module: row_clear_ctrl

Interface
REQ-001 Parameter BLOCKS_WIDE, default 10, cells per row.
REQ-002 Parameter BLOCKS_HIGH, default 22, rows per board; row 0 is the top row.
REQ-003 Parameter BITS_Y_POS, default 5, row-index width.
REQ-004 Parameter BITS_SCORE, default 14, score width.
REQ-005 clk  in  1  single clock; all state updates on posedge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  piece landed; request a clear pass.
REQ-008 pause  in  1  freezes the FSM, row counter, board and score.
REQ-009 board_in  in  BLOCKS_WIDE*BLOCKS_HIGH  occupancy; row r is bits [r*BLOCKS_WIDE +: BLOCKS_WIDE].
REQ-010 board_out  out  BLOCKS_WIDE*BLOCKS_HIGH  registered compacted board, same packing.
REQ-011 busy  out  1  high while the FSM is not IDLE.
REQ-012 done  out  1  one-cycle pass-complete pulse.
REQ-013 lines_cleared  out  BITS_Y_POS  rows removed in the last pass; held until the next pass.
REQ-014 score  out  BITS_SCORE  accumulated score.

Function
REQ-015 FSM states SHALL be IDLE, SCAN, SHIFT and FINISH.
REQ-016 In IDLE with start=1 and pause=0: board_out<=board_in, row<=BLOCKS_HIGH-1, count<=0, go to SCAN.
REQ-017 start SHALL be ignored in any state other than IDLE.
REQ-018 SCAN, row full (AND of its BLOCKS_WIDE bits): go to SHIFT with row unchanged.
REQ-019 SCAN, row not full, row==0: go to FINISH.
REQ-020 SCAN, row not full, row>0: row<=row-1, stay in SCAN.
REQ-021 SHIFT: rows 0..row-1 move to 1..row, row 0 is zeroed, rows >row unchanged, count<=count+1, return to SCAN at the same row (rescan).
REQ-022 FINISH: lines_cleared<=count, score<=score+points(count), done<=1, go to IDLE.
REQ-023 points: 0->0, 1->1, 2->3, 3->5, >=4->8.
REQ-024 score SHALL saturate at 2^BITS_SCORE-1 and never wrap.
REQ-025 count SHALL saturate at BLOCKS_HIGH; a full-board input yields exactly BLOCKS_HIGH clears.
REQ-026 done SHALL be 1 for exactly one cycle, the first IDLE cycle after FINISH, and 0 otherwise.
REQ-027 Latency: start sampled at edge E0 -> done high after edge E0+23+2k (k = rows cleared, BLOCKS_HIGH=22).
REQ-028 pause=1 SHALL hold state, row, count, board_out and score; done SHALL still drop after its single cycle; a start seen while pause=1 is not captured.
REQ-029 busy SHALL be combinational from the state (state != IDLE).
REQ-030 board_out SHALL change only on the IDLE->SCAN load edge and on SHIFT edges.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, row=0, count=0, board_out=0, busy=0, done=0, lines_cleared=0 and score=0, regardless of the clock.
REQ-032 rst during SCAN/SHIFT/FINISH SHALL abort the pass with no score update; after release, operation resumes from IDLE on the next start.

Verification
REQ-033 Empty board, start -> done after E0+23, lines_cleared=0, score=0, board_out=0.
REQ-034 Row 21 all ones, row 20=10'h155, others 0 -> done at E0+25, row 21=10'h155, rows 0..20=0, lines_cleared=1, score=1.
REQ-035 Rows 18..21 full, row 17=10'h0F0 -> done at E0+31, row 21=10'h0F0, other rows 0, lines_cleared=4, score +8.
REQ-036 Rows 21 and 19 full, row 20=10'h001, row 18=10'h200 -> row 21=10'h001, row 20=10'h200, rest 0, lines_cleared=2, score +3.
REQ-037 pause held 5 cycles mid-SCAN plus start pulses while busy -> done delayed by exactly 5 cycles, no second pass starts, results unchanged.
REQ-038 rst asserted between edges during SCAN -> all outputs 0 before the next edge; a following empty-board start completes per REQ-033.

Source files
------------

// File: rtl/row_clear_ctrl.sv
// Row-clear controller: scans a landed board bottom-up, removes full rows,
// compacts the stack and accumulates a saturating score.
module row_clear_ctrl #(
  parameter int BLOCKS_WIDE = 10,
  parameter int BLOCKS_HIGH = 22,
  parameter int BITS_Y_POS  = 5,
  parameter int BITS_SCORE  = 14
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               pause,
  input  logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] board_in,
  output logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] board_out,
  output logic                               busy,
  output logic                               done,
  output logic [BITS_Y_POS-1:0]              lines_cleared,
  output logic [BITS_SCORE-1:0]              score
);

  localparam int NB = BLOCKS_WIDE * BLOCKS_HIGH;
  localparam int SW = BITS_SCORE + 1;

  localparam logic [BITS_Y_POS-1:0] ROW_TOP = BITS_Y_POS'(BLOCKS_HIGH - 1);
  localparam logic [BITS_Y_POS-1:0] CNT_MAX = BITS_Y_POS'(BLOCKS_HIGH);
  localparam logic [SW-1:0]         SC_MAX  = {1'b0, {BITS_SCORE{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SHIFT,
    FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [BITS_Y_POS-1:0] row_q, row_d;
  logic [BITS_Y_POS-1:0] count_q, count_d;
  logic [NB-1:0]         board_q, board_d;
  logic [BITS_Y_POS-1:0] lines_q, lines_d;
  logic [BITS_SCORE-1:0] score_q, score_d;
  logic                  done_q, done_d;

  logic [BLOCKS_HIGH-1:0] full_rows;
  logic                   row_full;
  logic [NB-1:0]          shifted;
  logic [3:0]             pts;
  logic [SW-1:0]          sum;

  function automatic logic [3:0] points(input logic [BITS_Y_POS-1:0] n);
    case (n)
      BITS_Y_POS'(0): points = 4'd0;
      BITS_Y_POS'(1): points = 4'd1;
      BITS_Y_POS'(2): points = 4'd3;
      BITS_Y_POS'(3): points = 4'd5;
      default:        points = 4'd8;
    endcase
  endfunction

  always_comb begin
    for (int r = 0; r < BLOCKS_HIGH; r++) begin
      full_rows[r] = &board_q[r*BLOCKS_WIDE +: BLOCKS_WIDE];
    end
  end

  assign row_full = full_rows[row_q];

  // Everything at or above the cleared row drops by one; row 0 refills empty.
  always_comb begin
    shifted = board_q;
    shifted[0 +: BLOCKS_WIDE] = '0;
    for (int r = 1; r < BLOCKS_HIGH; r++) begin
      if (BITS_Y_POS'(r) <= row_q) begin
        shifted[r*BLOCKS_WIDE +: BLOCKS_WIDE] =
          board_q[(r-1)*BLOCKS_WIDE +: BLOCKS_WIDE];
      end
    end
  end

  assign pts = points(count_q);
  assign sum = {1'b0, score_q} + SW'(pts);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    count_d = count_q;
    board_d = board_q;
    lines_d = lines_q;
    score_d = score_q;
    done_d  = 1'b0;
    if (!pause) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            board_d = board_in;
            row_d   = ROW_TOP;
            count_d = '0;
            state_d = SCAN;
          end
        end
        SCAN: begin
          if (row_full) begin
            state_d = SHIFT;
          end else if (row_q == '0) begin
            state_d = FINISH;
          end else begin
            row_d = row_q - BITS_Y_POS'(1);
          end
        end
        SHIFT: begin
          board_d = shifted;
          if (count_q != CNT_MAX) begin
            count_d = count_q + BITS_Y_POS'(1);
          end
          state_d = SCAN;
        end
        FINISH: begin
          lines_d = count_q;
          score_d = (sum > SC_MAX) ? SC_MAX[BITS_SCORE-1:0]
                                   : sum[BITS_SCORE-1:0];
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      count_q <= '0;
      board_q <= '0;
      lines_q <= '0;
      score_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      count_q <= count_d;
      board_q <= board_d;
      lines_q <= lines_d;
      score_q <= score_d;
      done_q  <= done_d;
    end
  end

  assign board_out     = board_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign lines_cleared = lines_q;
  assign score         = score_q;

endmodule

// File: tb/tb_row_clear_ctrl.sv
// Directed bench for row_clear_ctrl with a result scoreboard and a
// narrow-score twin instance for saturation.
module tb_row_clear_ctrl;

  localparam int W  = 10;
  localparam int H  = 22;
  localparam int NB = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic [NB-1:0] board_in = '0;

  logic [NB-1:0] board_out, bo_s;
  logic          busy, busy_s;
  logic          done, done_s;
  logic [4:0]    lines_cleared, lc_s;
  logic [13:0]   score;
  logic [4:0]    sc_s;

  row_clear_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .board_in(board_in), .board_out(board_out), .busy(busy),
    .done(done), .lines_cleared(lines_cleared), .score(score)
  );

  row_clear_ctrl #(.BITS_SCORE(5)) dut_s (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .board_in(board_in), .board_out(bo_s), .busy(busy_s),
    .done(done_s), .lines_cleared(lc_s), .score(sc_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            lat;
    logic [4:0]    lines;
    logic [NB-1:0] brd;
    logic [13:0]   sc;
    logic [4:0]    scs;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   tot_pts = 0;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] rw(input int r, input logic [W-1:0] v);
    logic [NB-1:0] b;
    b = '0;
    b[r*W +: W] = v;
    return b;
  endfunction

  function automatic int pts_of(input int k);
    case (k)
      0: return 0;
      1: return 1;
      2: return 3;
      3: return 5;
      default: return 8;
    endcase
  endfunction

  task automatic do_pass(input logic [NB-1:0] b, input logic [NB-1:0] bexp,
                         input int k, input int pa, input int pl,
                         input bit kick);
    exp_t e;
    int   n;
    tot_pts += pts_of(k);
    e.lat   = 23 + 2 * k + pl;
    e.lines = 5'(k);
    e.brd   = bexp;
    e.sc    = (tot_pts > 16383) ? 14'h3FFF : 14'(tot_pts);
    e.scs   = (tot_pts > 31) ? 5'd31 : 5'(tot_pts);
    q.push_back(e);
    @(negedge clk);
    board_in = b;
    start = 1'b1;
    @(posedge clk);
    n = 0;
    @(negedge clk);
    start = 1'b0;
    board_in = ~b;
    chk("busy_run", busy, 1'b1);
    while (done !== 1'b1 && n < 300) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (pl > 0) begin
        if (n == pa) pause = 1'b1;
        if (n == pa + pl) pause = 1'b0;
      end
      if (kick) start = (n == 3 || n == pa + 2);
    end
    start = 1'b0;
    pause = 1'b0;
    e = q.pop_front();
    chk("latency", n, e.lat);
    chk("lines", lines_cleared, e.lines);
    chk("score", score, e.sc);
    chk("board", board_out, e.brd);
    chk("busy_done", busy, 1'b0);
    chk("twin_done", done_s, 1'b1);
    chk("twin_lines", lc_s, e.lines);
    chk("twin_board", bo_s, e.brd);
    chk("twin_score", sc_s, e.scs);
    @(negedge clk);
    chk("done_drop", done, 1'b0);
    chk("no_rerun", busy, 1'b0);
  endtask

  logic [NB-1:0] b2, b3, b4, bf;

  initial begin
    b2 = rw(21, 10'h3FF) | rw(20, 10'h155);
    b3 = rw(21, 10'h3FF) | rw(20, 10'h3FF) | rw(19, 10'h3FF) |
         rw(18, 10'h3FF) | rw(17, 10'h0F0);
    b4 = rw(21, 10'h3FF) | rw(20, 10'h001) | rw(19, 10'h3FF) |
         rw(18, 10'h200);
    bf = '1;

    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_board", board_out, '0);
    chk("rst_lines", lines_cleared, 5'd0);
    chk("rst_score", score, 14'd0);
    @(negedge clk);
    rst = 1'b0;

    do_pass('0, '0, 0, 0, 0, 1'b0);
    do_pass(b2, rw(21, 10'h155), 1, 0, 0, 1'b0);
    do_pass(b3, rw(21, 10'h0F0), 4, 0, 0, 1'b0);
    do_pass(b4, rw(21, 10'h001) | rw(20, 10'h200), 2, 0, 0, 1'b0);
    do_pass(b4, rw(21, 10'h001) | rw(20, 10'h200), 2, 5, 5, 1'b1);
    do_pass(bf, '0, 22, 0, 0, 1'b0);
    do_pass(bf, '0, 22, 0, 0, 1'b0);
    do_pass(bf, '0, 22, 0, 0, 1'b0);

    @(negedge clk);
    board_in = b2;
    pause = 1'b1;
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("pause_idle_busy", busy, 1'b0);
    end
    start = 1'b0;
    pause = 1'b0;
    @(negedge clk);
    chk("pause_idle_busy2", busy, 1'b0);
    chk("pause_idle_board", board_out, '0);

    @(negedge clk);
    board_in = b3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_board", board_out, '0);
    chk("arst_lines", lines_cleared, 5'd0);
    chk("arst_score", score, 14'd0);
    chk("arst_twin_score", sc_s, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    tot_pts = 0;
    @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);

    do_pass('0, '0, 0, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
